// File: rtl/rv32i_mem_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and the ALU load/store path.
// Each access runs IDLE -> CMD -> (RESP) -> DONE; a response timeout raises bus_err and completes with zero data.
module rv32i_mem_arbiter #(
    parameter int TIMEOUT       = 255,
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic        clr_load_op,
    output logic [31:0] ld_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_waitreq,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        owner_data;
    logic        is_write;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt;
    logic        flushed;
    logic        timed_out;

    logic        data_req;
    logic        grant;
    logic        grant_data;
    logic        grant_wr;
    logic [31:0] sel_addr;
    logic        to_hit;
    logic        capture;
    logic [31:0] cap_word;
    logic        flush_seen;

    assign data_req   = load | store;
    assign grant_wr   = grant_data & store;
    assign sel_addr   = grant_data ? addr : if_addr;
    assign flush_seen = if_flush & if_req & ~owner_data;
    assign cap_word   = to_hit ? 32'h0 : mem_rdata;
    assign capture    = (state == CMD || state == RESP) && state_nxt == DONE;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_data = 1'b0;
        to_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && (DATA_PRIORITY || !if_req)) begin
                    grant      = 1'b1;
                    grant_data = 1'b1;
                end else if (if_req) begin
                    grant = 1'b1;
                end
                if (grant) state_nxt = CMD;
            end
            CMD: begin
                if (!mem_waitreq) state_nxt = is_write ? DONE : RESP;
                // A read accepted on the final allowed cycle still cannot return in time.
                if (cnt == TO_LAST && !(!mem_waitreq && is_write)) begin
                    to_hit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_nxt = DONE;
                end else if (cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            is_write   <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            flushed    <= 1'b0;
            timed_out  <= 1'b0;
            ld_data    <= '0;
            if_rdata   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_data <= grant_data;
                        is_write   <= grant_wr;
                        addr_q     <= sel_addr & 32'hFFFF_FFFC;
                        be_q       <= grant_wr ? st_be : 4'hF;
                        wdata_q    <= grant_wr ? st_data : 32'h0;
                        cnt        <= '0;
                        flushed    <= 1'b0;
                        timed_out  <= 1'b0;
                    end
                end
                CMD, RESP: begin
                    cnt <= cnt + 16'd1;
                    if (flush_seen) flushed <= 1'b1;
                end
                default: ;
            endcase
            if (capture) begin
                if (to_hit) timed_out <= 1'b1;
                if (owner_data && !is_write) ld_data <= cap_word;
                if (!owner_data) if_rdata <= cap_word;
            end
        end
    end

    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign mem_read    = (state == CMD) & ~is_write;
    assign mem_write   = (state == CMD) & is_write;
    // Stall falls in the DONE cycle so the ALU can retire the op on that edge.
    assign stall       = data_req & ~(state == DONE && owner_data);
    assign clr_load_op = (state == DONE) & owner_data & ~is_write;
    assign if_valid    = (state == DONE) & ~owner_data & ~flushed & ~(if_flush & if_req);
    assign bus_err     = (state == DONE) & timed_out;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: cycle tables for the directed corner cases, then
// random fetch/load/store traffic against a word-memory model and a random-latency slave.
module tb_rv32i_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        load, store, stall, clr_load_op;
    logic [31:0] addr, st_data, ld_data;
    logic [3:0]  st_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_waitreq, mem_rvalid, bus_err;
    logic [3:0]  mem_be;

    rv32i_mem_arbiter #(.TIMEOUT(TO), .DATA_PRIORITY(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .load(load), .store(store), .addr(addr), .st_be(st_be), .st_data(st_data),
        .stall(stall), .clr_load_op(clr_load_op), .ld_data(ld_data),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_waitreq(mem_waitreq), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // in = {rst, load, store, if_req, if_flush}; ex = {stall, mem_read, mem_write, clr_load_op, if_valid, bus_err}
    typedef struct {
        logic [4:0]  in;
        logic [31:0] a, ia;
        logic        wr, rv;
        logic [31:0] rd;
        logic [5:0]  ex;
        logic [31:0] maddr, ldd, ifd;
        logic        z;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] in, input logic [31:0] a, input logic [31:0] ia,
                                input logic wr, input logic rv, input logic [31:0] rd,
                                input logic [5:0] ex, input logic [31:0] maddr,
                                input logic [31:0] ldd, input logic [31:0] ifd, input logic z);
        vec_t v;
        v.in = in; v.a = a; v.ia = ia; v.wr = wr; v.rv = rv; v.rd = rd;
        v.ex = ex; v.maddr = maddr; v.ldd = ldd; v.ifd = ifd; v.z = z;
        return v;
    endfunction

    vec_t tbl[$];

    // Memory model for the random phase: unwritten words read a pattern derived from the address.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rdw(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A_0000;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // best-case load, rvalid in IDLE ignored
        tbl.push_back(mk(5'b01000, 32'h400, 0, 0, 0, 0,            6'b100000, 0,      0,            0, 0));
        tbl.push_back(mk(5'b01000, 32'h400, 0, 0, 0, 0,            6'b110000, 32'h400,0,            0, 0));
        tbl.push_back(mk(5'b01000, 32'h400, 0, 0, 1, 32'hDEADBEEF, 6'b100000, 0,      0,            0, 0));
        tbl.push_back(mk(5'b01000, 32'h400, 0, 0, 0, 0,            6'b000100, 0,      32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b00000, 0,       0, 0, 1, 32'h12345678, 6'b000000, 0,      32'hDEADBEEF, 0, 0));
        // store with three waitreq cycles
        tbl.push_back(mk(5'b00100, 32'h1004, 0, 0, 0, 0, 6'b100000, 0,        32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b00100, 32'h1004, 0, 1, 0, 0, 6'b101000, 32'h1004, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b00100, 32'h1004, 0, 1, 0, 0, 6'b101000, 32'h1004, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b00100, 32'h1004, 0, 1, 0, 0, 6'b101000, 32'h1004, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b00100, 32'h1004, 0, 0, 0, 0, 6'b101000, 32'h1004, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b00100, 32'h1004, 0, 0, 0, 0, 6'b000000, 0,        32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b00000, 0,        0, 0, 0, 0, 6'b000000, 0,        32'hDEADBEEF, 0, 0));
        // simultaneous fetch and load: data first
        tbl.push_back(mk(5'b01010, 32'h400, 32'h200, 0, 0, 0,            6'b100000, 0,       32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b01010, 32'h400, 32'h200, 0, 0, 0,            6'b110000, 32'h400, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b01010, 32'h400, 32'h200, 0, 1, 32'h11112222, 6'b100000, 0,       32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(5'b01010, 32'h400, 32'h200, 0, 0, 0,            6'b000100, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0,       32'h200, 0, 0, 0,            6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0,       32'h200, 0, 0, 0,            6'b010000, 32'h200, 32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0,       32'h200, 0, 1, 32'h33334444, 6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0,       32'h200, 0, 0, 0,            6'b000010, 0,       32'h11112222, 32'h33334444, 0));
        tbl.push_back(mk(5'b00000, 0,       0,       0, 0, 0,            6'b000000, 0,       32'h11112222, 0, 0));
        // flushed fetch completes on the bus silently, next fetch is normal
        tbl.push_back(mk(5'b00010, 0, 32'h100, 0, 0, 0,            6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0, 32'h100, 0, 0, 0,            6'b010000, 32'h100, 32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00011, 0, 32'h100, 0, 0, 0,            6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00000, 0, 0,       0, 1, 32'h55555555, 6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00000, 0, 0,       0, 0, 0,            6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0, 32'h104, 0, 0, 0,            6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0, 32'h104, 0, 0, 0,            6'b010000, 32'h104, 32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0, 32'h104, 0, 1, 32'h66666666, 6'b000000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b00010, 0, 32'h104, 0, 0, 0,            6'b000010, 0,       32'h11112222, 32'h66666666, 0));
        tbl.push_back(mk(5'b00000, 0, 0,       0, 0, 0,            6'b000000, 0,       32'h11112222, 0, 0));
        // timeout: 8 cycles in CMD/RESP with no rvalid
        tbl.push_back(mk(5'b01000, 32'h800, 0, 0, 0, 0, 6'b100000, 0,       32'h11112222, 0, 0));
        tbl.push_back(mk(5'b01000, 32'h800, 0, 0, 0, 0, 6'b110000, 32'h800, 32'h11112222, 0, 0));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(5'b01000, 32'h800, 0, 0, 0, 0, 6'b100000, 0, 32'h11112222, 0, 0));
        tbl.push_back(mk(5'b01000, 32'h800, 0, 0, 0, 0, 6'b000101, 0, 0, 0, 0));
        tbl.push_back(mk(5'b00000, 0,       0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
        // reset during RESP, late rvalid after release
        tbl.push_back(mk(5'b01000, 32'h400, 0, 0, 0, 0,            6'b100000, 0,       0, 0, 0));
        tbl.push_back(mk(5'b01000, 32'h400, 0, 0, 0, 0,            6'b110000, 32'h400, 0, 0, 0));
        tbl.push_back(mk(5'b10000, 0,       0, 0, 0, 0,            6'b000000, 0,       0, 0, 0));
        tbl.push_back(mk(5'b00000, 0,       0, 0, 0, 0,            6'b000000, 0,       0, 0, 1));
        tbl.push_back(mk(5'b00000, 0,       0, 0, 1, 32'h77777777, 6'b000000, 0,       0, 0, 1));
        tbl.push_back(mk(5'b00000, 0,       0, 0, 0, 0,            6'b000000, 0,       0, 0, 1));

        reset_n = 1'b0; if_req = 0; if_addr = 0; if_flush = 0; load = 0; store = 0;
        addr = 0; st_be = 4'hC; st_data = 32'hABCD0000;
        mem_waitreq = 0; mem_rdata = 0; mem_rvalid = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst stall", stall, 0);
        chk("rst mem_read", mem_read, 0);
        chk("rst mem_write", mem_write, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_be", mem_be, 0);
        chk("rst clr_load_op", clr_load_op, 0);
        chk("rst if_valid", if_valid, 0);
        chk("rst bus_err", bus_err, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            reset_n = ~v.in[4]; load = v.in[3]; store = v.in[2]; if_req = v.in[1]; if_flush = v.in[0];
            addr = v.a; if_addr = v.ia; mem_waitreq = v.wr; mem_rvalid = v.rv; mem_rdata = v.rd;
            #1;
            chk($sformatf("r%0d stall", i), stall, v.ex[5]);
            chk($sformatf("r%0d mem_read", i), mem_read, v.ex[4]);
            chk($sformatf("r%0d mem_write", i), mem_write, v.ex[3]);
            chk($sformatf("r%0d clr_load_op", i), clr_load_op, v.ex[2]);
            chk($sformatf("r%0d if_valid", i), if_valid, v.ex[1]);
            chk($sformatf("r%0d bus_err", i), bus_err, v.ex[0]);
            chk($sformatf("r%0d ld_data", i), ld_data, v.ldd);
            if (v.ex[4] || v.ex[3]) begin
                chk($sformatf("r%0d mem_addr", i), mem_addr, v.maddr);
                chk($sformatf("r%0d mem_be", i), mem_be, v.ex[3] ? 32'hC : 32'hF);
            end
            if (v.ex[3]) chk($sformatf("r%0d mem_wdata", i), mem_wdata, 32'hABCD0000);
            if (v.ex[1]) chk($sformatf("r%0d if_rdata", i), if_rdata, v.ifd);
            if (v.z) begin
                chk($sformatf("r%0d z mem_addr", i), mem_addr, 0);
                chk($sformatf("r%0d z mem_be", i), mem_be, 0);
                chk($sformatf("r%0d z mem_wdata", i), mem_wdata, 0);
                chk($sformatf("r%0d z if_rdata", i), if_rdata, 0);
            end
            @(posedge clk);
            #1;
        end

        // Random traffic. Each step runs just after the edge: request variables still hold
        // what the arbiter sampled on that edge; slave responses set here apply to this cycle.
        begin
            bit ld_on = 0, st_on = 0, f_on = 0, stop = 0;
            bit cmd_act = 0, rd_pend = 0;
            int wcnt = 0, dcnt = 0, cur_kind = 0, n_done = 0, d_age = 0, f_age = 0;
            logic [31:0] d_addr = 0, f_addr = 0, d_sd = 0, cur_addr = 0, hold = 0;
            logic [3:0]  d_be = 0;
            logic        wr, rv;
            logic [31:0] rd;
            for (int cyc = 0; cyc < 4000 && !stop; cyc++) begin
                bit issue_ok;
                issue_ok = (cyc < 3500);
                if ((mem_read || mem_write) && !cmd_act) begin
                    int kind;
                    logic [31:0] ea;
                    cmd_act = 1; wcnt = $urandom_range(0, 2);
                    if (ld_on || st_on) begin kind = st_on ? 2 : 1; ea = d_addr & 32'hFFFF_FFFC; end
                    else if (f_on) begin kind = 3; ea = f_addr & 32'hFFFF_FFFC; end
                    else kind = 0;
                    chk("rnd cmd owner", (kind == 0) ? 0 : 1, 1);
                    chk("rnd cmd write", mem_write, (kind == 2) ? 1 : 0);
                    chk("rnd cmd addr", mem_addr, ea);
                    chk("rnd cmd be", mem_be, (kind == 2) ? {28'h0, d_be} : 32'hF);
                    if (kind == 2) chk("rnd cmd wdata", mem_wdata, d_sd);
                    cur_kind = kind; cur_addr = ea;
                end
                rv = 0; rd = $urandom;
                wr = $urandom_range(0, 1);
                if (cmd_act) begin
                    if (wcnt > 0) begin wr = 1; wcnt--; end
                    else begin
                        wr = 0; cmd_act = 0;
                        if (mem_write) begin
                            logic [31:0] w;
                            w = rdw(cur_addr);
                            for (int b = 0; b < 4; b++) if (d_be[b]) w[8*b +: 8] = d_sd[8*b +: 8];
                            mem[cur_addr] = w;
                        end else begin
                            rd_pend = 1; dcnt = $urandom_range(1, 3); hold = rdw(cur_addr);
                        end
                    end
                end else if (rd_pend) begin
                    dcnt--;
                    if (dcnt == 0) begin rv = 1; rd = hold; rd_pend = 0; end
                end else begin
                    rv = ($urandom_range(0, 3) == 0);
                end

                if (bus_err) chk("rnd bus_err", bus_err, 0);
                if (clr_load_op) begin
                    chk("rnd ld owner", cur_kind, 1);
                    chk("rnd ld_data", ld_data, rdw(cur_addr));
                    ld_on = 0; cur_kind = 0; d_age = 0; n_done++;
                end else if (ld_on && !stall) begin
                    chk("rnd ld release", clr_load_op, 1);
                    ld_on = 0;
                end
                if (st_on && !stall) begin
                    chk("rnd st owner", cur_kind, 2);
                    st_on = 0; cur_kind = 0; d_age = 0; n_done++;
                end
                if (if_valid) begin
                    chk("rnd if owner", cur_kind, 3);
                    chk("rnd if_rdata", if_rdata, rdw(cur_addr));
                    f_on = 0; cur_kind = 0; f_age = 0; n_done++;
                end

                if (issue_ok && !ld_on && !st_on && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) ld_on = 1; else st_on = 1;
                    d_addr = 32'h2000 + $urandom_range(0, 63);
                    d_be = 4'($urandom_range(1, 15)); d_sd = $urandom;
                end
                if (issue_ok && !f_on && $urandom_range(0, 2) == 0) begin
                    f_on = 1; f_addr = 32'h2000 + $urandom_range(0, 63);
                end
                if (ld_on || st_on) d_age++;
                if (f_on) f_age++;
                if (d_age > 200 || f_age > 200) begin
                    chk("rnd request timeout", 1, 0);
                    stop = 1;
                end
                if (!issue_ok && !ld_on && !st_on && !f_on && !cmd_act && !rd_pend) stop = 1;

                load = ld_on; store = st_on; addr = d_addr; st_be = d_be; st_data = d_sd;
                if_req = f_on; if_addr = f_addr; if_flush = 0;
                mem_waitreq = wr; mem_rvalid = rv; mem_rdata = rd;
                @(posedge clk);
                #1;
            end
            chk("rnd drained", (ld_on || st_on || f_on) ? 1 : 0, 0);
            chk("rnd enough traffic", (n_done > 50) ? 1 : 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
